time_parameters: RTL and testbench

- Holds the three programmable timing parameters of the traffic-light controller:
  - base interval (tBASE)
  - extended interval (tEXT)
  - yellow interval (tYEL)
- Operators reprogram one parameter at a time through a selector/value pair and a synchronized program strobe.
- The FSM/timer side reads back the parameter for the current interval through a combinational mux.
- Sits between the synchronized user-input block and the timer/FSM.

---
 rtl/tl_pkg.sv | 19 +
 rtl/tp_reg.sv | 27 ++
 rtl/time_parameters.sv | 53 +++++
 tb/tb_time_parameters.sv | 131 +++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared traffic-light constants: time width, parameter selectors, default intervals.
package tl_pkg;
  localparam int TIME_W = 4;
  localparam int NUM_TP = 3;

  localparam logic [1:0] SEL_BASE = 2'b00;
  localparam logic [1:0] SEL_EXT  = 2'b01;
  localparam logic [1:0] SEL_YEL  = 2'b10;

  localparam logic [TIME_W-1:0] DEF_BASE = 4'd6;
  localparam logic [TIME_W-1:0] DEF_EXT  = 4'd3;
  localparam logic [TIME_W-1:0] DEF_YEL  = 4'd2;

  typedef struct packed {
    logic              prog;
    logic [1:0]        sel;
    logic [TIME_W-1:0] val;
  } tp_wr_req_t;
endpackage

// File: rtl/tp_reg.sv
// One timing-parameter register: sync reset to default, write enable, zero writes rejected.
module tp_reg #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] DEF   = '0
) (
  input  logic             clk,
  input  logic             reset_sync,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] q
);
  // Power-up value matches the reset default so the read path is never X.
  logic [WIDTH-1:0] r_q = DEF;
  logic [WIDTH-1:0] r_d;

  always_comb begin
    r_d = r_q;
    if (we && (wdata != '0)) r_d = wdata;
  end

  always_ff @(posedge clk) begin
    if (reset_sync) r_q <= DEF;
    else            r_q <= r_d;
  end

  assign q = r_q;
endmodule

// File: rtl/time_parameters.sv
// Programmable tBASE/tEXT/tYEL store with selector write decode and combinational read mux.
module time_parameters
  import tl_pkg::*;
#(
  parameter int               WIDTH      = TIME_W,
  parameter logic [WIDTH-1:0] T_BASE_DEF = DEF_BASE,
  parameter logic [WIDTH-1:0] T_EXT_DEF  = DEF_EXT,
  parameter logic [WIDTH-1:0] T_YEL_DEF  = DEF_YEL
) (
  input  logic             clk,
  input  logic             reset_sync,
  input  logic [1:0]       tp_sel,
  input  logic [WIDTH-1:0] t_val,
  input  logic             prog_sync,
  input  logic [1:0]       interval,
  output logic [WIDTH-1:0] tp_val
);
  // Index order matches the selector encoding: 0=BASE, 1=EXT, 2=YEL.
  localparam logic [NUM_TP-1:0][WIDTH-1:0] DEFS = {T_YEL_DEF, T_EXT_DEF, T_BASE_DEF};

  tp_wr_req_t                   wr_req;
  logic [NUM_TP-1:0]            we;
  logic [NUM_TP-1:0][WIDTH-1:0] regs;

  always_comb begin
    wr_req      = '0;
    wr_req.prog = prog_sync;
    wr_req.sel  = tp_sel;
    wr_req.val  = TIME_W'(t_val);
  end

  for (genvar i = 0; i < NUM_TP; i++) begin : g_tp
    assign we[i] = wr_req.prog && (wr_req.sel == 2'(i));

    tp_reg #(.WIDTH(WIDTH), .DEF(DEFS[i])) u_reg (
      .clk        (clk),
      .reset_sync (reset_sync),
      .we         (we[i]),
      .wdata      (WIDTH'(wr_req.val)),
      .q          (regs[i])
    );
  end

  // Unused selector code falls back to the base interval.
  always_comb begin
    tp_val = regs[SEL_BASE];
    case (interval)
      SEL_EXT: tp_val = regs[SEL_EXT];
      SEL_YEL: tp_val = regs[SEL_YEL];
      default: tp_val = regs[SEL_BASE];
    endcase
  end
endmodule

// File: tb/tb_time_parameters.sv
// Directed bench for time_parameters with an expected-value scoreboard queue.
module tb_time_parameters;
  logic       clk = 1'b0;
  logic       reset_sync = 1'b0;
  logic [1:0] tp_sel = 2'b00;
  logic [3:0] t_val = 4'd0;
  logic       prog_sync = 1'b0;
  logic [1:0] interval = 2'b00;
  logic [3:0] tp_val;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [3:0] exp_q[$];
  string      tag_q[$];

  time_parameters dut (
    .clk        (clk),
    .reset_sync (reset_sync),
    .tp_sel     (tp_sel),
    .t_val      (t_val),
    .prog_sync  (prog_sync),
    .interval   (interval),
    .tp_val     (tp_val)
  );

  always #5 clk = ~clk;

  // One clock edge with the given controls; controls drop right after the edge.
  task automatic cyc(input logic rst, input logic prog, input logic [1:0] sel, input logic [3:0] val);
    @(negedge clk);
    reset_sync = rst;
    prog_sync  = prog;
    tp_sel     = sel;
    t_val      = val;
    @(posedge clk);
    #1;
    reset_sync = 1'b0;
    prog_sync  = 1'b0;
  endtask

  // Select a read interval, queue the expected value, then pop and compare.
  task automatic rd(input logic [1:0] intv, input logic [3:0] exp, input string tag);
    logic [3:0] e;
    string      t;
    interval = intv;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_cmp++;
    assert (tp_val === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", t, tp_val, e);
    end
  endtask

  initial begin
    // Power-up, no reset applied yet
    rd(2'b00, 4'd6, "pwrup_base");
    rd(2'b01, 4'd3, "pwrup_ext");
    rd(2'b10, 4'd2, "pwrup_yel");

    cyc(1'b1, 1'b0, 2'b00, 4'd0);
    cyc(1'b1, 1'b0, 2'b00, 4'd0);
    rd(2'b00, 4'd6, "rst_base");
    rd(2'b01, 4'd3, "rst_ext");
    rd(2'b10, 4'd2, "rst_yel");
    rd(2'b11, 4'd6, "rst_fallback");

    // Program BASE=2, held two cycles
    interval = 2'b00;
    cyc(1'b0, 1'b1, 2'b00, 4'd2);
    rd(2'b00, 4'd2, "base_first_edge");
    cyc(1'b0, 1'b1, 2'b00, 4'd2);
    rd(2'b00, 4'd2, "base_held");
    rd(2'b01, 4'd3, "base_ext_kept");
    rd(2'b10, 4'd2, "base_yel_kept");
    cyc(1'b1, 1'b0, 2'b00, 4'd0);
    cyc(1'b1, 1'b0, 2'b00, 4'd0);
    rd(2'b00, 4'd6, "base_after_rst");

    // Program EXT and YEL
    cyc(1'b0, 1'b1, 2'b01, 4'd9);
    cyc(1'b0, 1'b1, 2'b10, 4'd5);
    rd(2'b01, 4'd9, "ext_9");
    rd(2'b10, 4'd5, "yel_5");
    rd(2'b00, 4'd6, "base_still_6");

    // Unused selector writes nothing
    cyc(1'b0, 1'b1, 2'b11, 4'd15);
    rd(2'b00, 4'd6, "sel11_base");
    rd(2'b01, 4'd9, "sel11_ext");
    rd(2'b10, 4'd5, "sel11_yel");
    rd(2'b11, 4'd6, "sel11_fallback");

    // Zero write rejected
    cyc(1'b0, 1'b1, 2'b01, 4'd0);
    rd(2'b01, 4'd9, "zero_ext_kept");

    // Reset beats program in the same cycle
    cyc(1'b1, 1'b1, 2'b00, 4'd12);
    rd(2'b00, 4'd6, "rst_prio_base");
    rd(2'b01, 4'd3, "rst_prio_ext");
    rd(2'b10, 4'd2, "rst_prio_yel");

    // Max value, and selector/value changing while strobe stays high
    cyc(1'b0, 1'b1, 2'b10, 4'd15);
    rd(2'b10, 4'd15, "yel_15");
    @(negedge clk);
    prog_sync = 1'b1; tp_sel = 2'b00; t_val = 4'd7;
    @(negedge clk);
    tp_sel = 2'b01; t_val = 4'd4;
    @(negedge clk);
    prog_sync = 1'b0;
    rd(2'b00, 4'd7, "chg_base_7");
    rd(2'b01, 4'd4, "chg_ext_4");
    rd(2'b11, 4'd7, "chg_fallback");
    rd(2'b10, 4'd15, "chg_yel_kept");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
